// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MUL_W = 32;

endpackage

// File: rtl/add_w.sv
// W-bit ripple-style adder with carry-in and carry-out; used as the
// datapath adder of the sequential multiplier.
module add_w #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    // Widen by one bit so the carry-out falls out of the addition.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        sum   = total[W-1:0];
        cout  = total[W];
    end

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned multiplier: accepts two W-bit operands over a
// valid/ready handshake, performs one shift-and-add step per clock for
// exactly W cycles, then holds the 2W-bit product until it is taken.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(W);

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  mcand;
    logic [W-1:0]  acc_hi;
    logic [W-1:0]  acc_lo;
    logic [CW-1:0] cnt;

    logic [W-1:0]  addend;
    logic [W-1:0]  sum;
    logic          cout;
    logic          accept;

    // Multiplicand is added only when the current multiplier LSB is set.
    always_comb begin
        addend = acc_lo[0] ? mcand : '0;
    end

    add_w #(
        .W (W)
    ) u_add (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        accept = in_valid && in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: load on accept, shift the (2W+1)-bit {cout,sum,acc_lo} right
    // each RUN cycle so the carry-out lands in acc_hi's MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= a;
            acc_hi <= '0;
            acc_lo <= b;
            cnt    <= CW'(W - 1);
        end else if (state == RUN) begin
            acc_hi <= {cout, sum[W-1:1]};
            acc_lo <= {sum[0], acc_lo[W-1:1]};
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    always_comb begin
        product = {acc_hi, acc_lo};
    end

endmodule
